mul_div_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage.
- Its result is one input of the writeback-select mux; `busy` stalls the single-cycle core's PC/writeback until `done`.
- Shift-add multiply and restoring divide, one bit per cycle, sharing one XLEN-bit adder.

---
 rtl/mul_div_unit.sv | 144 ++++++++++++++
 tb/tb_mul_div_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle through a single shared adder; busy stalls the core until done.
module mul_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_a, r_b, r_hi, r_lo;
  logic            r_neg_q, r_neg_r;

  logic            w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_div_zero, w_ovf, w_fast, w_last, w_accept;
  logic [XLEN-1:0] w_fast_res;
  logic [XLEN+1:0] w_opa, w_opb, w_add;
  logic [XLEN:0]   w_acc;
  logic            w_ge;
  logic [XLEN-1:0] w_hi_n, w_lo_n, w_q, w_r, w_final;
  logic [2*XLEN-1:0] w_prod, w_prod_s;

  assign w_is_div   = r_f3[2];
  assign w_a_signed = r_f3[2] ? ~r_f3[0] : (r_f3[1:0] != 2'b11);
  assign w_b_signed = r_f3[2] ? ~r_f3[0] : ~r_f3[1];
  assign w_a_neg    = w_a_signed & r_a[XLEN-1];
  assign w_b_neg    = w_b_signed & r_b[XLEN-1];
  assign w_mag_a    = w_a_neg ? -r_a : r_a;
  assign w_mag_b    = w_b_neg ? -r_b : r_b;

  assign w_div_zero = w_is_div & (r_b == '0);
  assign w_ovf      = w_is_div & ~r_f3[0] & (r_a == {1'b1, {(XLEN-1){1'b0}}}) & (r_b == '1);
  assign w_fast     = w_div_zero | w_ovf;
  assign w_fast_res = w_div_zero ? (r_f3[1] ? r_a : '1) : (r_f3[1] ? '0 : r_a);

  assign w_last   = (r_cnt == CW'(XLEN-1));
  assign w_accept = start & ~flush;

  // One adder: hi + multiplicand for multiply, {hi,msb(lo)} - divisor for divide
  assign w_opa = w_is_div ? {1'b0, r_hi, r_lo[XLEN-1]} : {2'b00, r_hi};
  assign w_opb = {2'b00, r_b};
  assign w_add = w_opa + (w_is_div ? ~w_opb : w_opb) + (XLEN+2)'(w_is_div);

  assign w_acc = r_lo[0] ? w_add[XLEN:0] : {1'b0, r_hi};
  assign w_ge  = ~w_add[XLEN+1];

  always_comb begin
    w_hi_n = w_acc[XLEN:1];
    w_lo_n = {w_acc[0], r_lo[XLEN-1:1]};
    if (w_is_div) begin
      w_hi_n = w_ge ? w_add[XLEN-1:0] : {r_hi[XLEN-2:0], r_lo[XLEN-1]};
      w_lo_n = {r_lo[XLEN-2:0], w_ge};
    end
  end

  assign w_prod   = {w_hi_n, w_lo_n};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_q      = r_neg_q ? -w_lo_n : w_lo_n;
  assign w_r      = r_neg_r ? -w_hi_n : w_hi_n;

  always_comb begin
    if (w_is_div)
      w_final = r_f3[1] ? w_r : w_q;
    else if (r_f3[1:0] == 2'b00)
      w_final = w_prod_s[XLEN-1:0];
    else
      w_final = w_prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_accept ? S_PREP : S_IDLE;
      S_PREP:         w_next = w_fast ? S_DONE : S_CALC;
      S_CALC:         w_next = w_last ? S_DONE : S_CALC;
      default:        w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  assign busy = (r_state == S_PREP) || (r_state == S_CALC);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_f3    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      result  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a  <= op_a;
            r_b  <= op_b;
            r_f3 <= funct3;
          end
        end
        S_PREP: begin
          r_hi    <= '0;
          r_lo    <= w_mag_a;
          r_b     <= w_mag_b;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_cnt   <= '0;
          if (w_fast && !flush) result <= w_fast_res;
        end
        S_CALC: begin
          r_hi  <= w_hi_n;
          r_lo  <= w_lo_n;
          r_cnt <= r_cnt + 1'b1;
          if (w_last && !flush) result <= w_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: table of ops with hand-computed results,
// plus sequences for ignored starts, back-to-back start, flush and async reset.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called #1 after an edge; advances until done is seen or the budget runs out.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (!done && n <= 100) begin
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
    end
  endtask

  task automatic run_op(input vec_t v);
    int n, nb;
    funct3 = v.f3; op_a = v.a; op_b = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    wait_done(n, nb);
    check({v.name, " done"}, 32'(done), 32'd1);
    check({v.name, " latency"}, 32'(n), 32'(v.lat));
    check({v.name, " busy cycles"}, 32'(nb), 32'(v.lat));
    check({v.name, " result"}, result, v.exp);
    @(posedge clk); #1;
    check({v.name, " done width"}, 32'(done), 32'd0);
    check({v.name, " idle busy"}, 32'(busy), 32'd0);
    check({v.name, " result hold"}, result, v.exp);
  endtask

  vec_t vecs[17];

  initial begin
    int n, nb, ndone;

    vecs[0]  = '{"MUL",        3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{"MULH",       3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{"MULHU",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{"MULHSU",     3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{"DIV",        3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{"REM",        3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{"DIVU",       3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{"REMU",       3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{"DIV0",       3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{"REM0",       3'b110, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{"DIVOVF",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{"REMOVF",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{"DIVU0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{"REMU0",      3'b111, 32'd5,        32'd0,        32'd5,        1};
    vecs[14] = '{"DIVU big",   3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
    vecs[15] = '{"MUL shift",  3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33};
    vecs[16] = '{"MULH neg",   3'b001, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i]);

    // starts during busy are ignored; start in DONE launches the next op
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n <= 100) begin
      if (n == 4 || n == 19) begin
        start = 1'b1; funct3 = 3'b000; op_a = $urandom; op_b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("ignored start latency", 32'(n), 32'd33);
    check("ignored start result", result, 32'd14);
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b busy", 32'(busy), 32'd1);
    check("b2b done low", 32'(done), 32'd0);
    wait_done(n, nb);
    check("b2b latency", 32'(n), 32'd33);
    check("b2b result", result, 32'd12);
    @(posedge clk); #1;

    // flush mid-CALC
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("pre-flush busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush done", 32'(done), 32'd0);
    check("flush result", result, 32'd12);
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
    check("flush no done", 32'(ndone), 32'd0);
    check("flush result kept", result, 32'd12);

    // async reset mid-CALC
    funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // flush wins over start in IDLE
    funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    check("flush+start busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush+start busy 2", 32'(busy), 32'd0);
    check("flush+start done", 32'(done), 32'd0);

    run_op('{"MULHU small", 3'b011, 32'h00010000, 32'h00030000, 32'd3, 33});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
